// File: rtl/match_reporter.sv
// match_reporter: tags engine match vectors with stream byte offsets and queues them plus end-of-stream records for the host.
// Ports: clk, rst (sync, active-high); sod/eod/match_valid/match from the engine array;
// rec_valid/rec_ready/rec_eos/rec_offset/rec_match host drain handshake;
// hold back-pressure, overflow and offset_wrap sticky flags.
// Build option MATCH_REPORT_COUNT_EN adds match_count, a saturating per-stream count of non-zero match vectors.
module match_reporter #(
  parameter int NUM_ENG     = 3,
  parameter int OFFSET_W    = 16,
  parameter int DEPTH       = 8,
  parameter int HOLD_MARGIN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sod,
  input  logic                eod,
  input  logic                match_valid,
  input  logic [NUM_ENG-1:0]  match,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic                rec_eos,
  output logic [OFFSET_W-1:0] rec_offset,
  output logic [NUM_ENG-1:0]  rec_match,
  output logic                hold,
  output logic                overflow,
  output logic                offset_wrap
`ifdef MATCH_REPORT_COUNT_EN
  ,
  output logic [OFFSET_W-1:0] match_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = 1 + OFFSET_W + NUM_ENG;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] MARGIN = (AW+1)'(HOLD_MARGIN);
  typedef enum logic [1:0] {IDLE, STREAM, EOS} state_t;
  state_t state, state_n;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_n;
  logic [OFFSET_W-1:0] off, off_n, byte_off;
  logic [RW-1:0] wdata;
  logic take, hit, pop, space, mpush, eos_push, push, ovf_n, wrap_n, hold_n;
  assign rec_valid = cnt != '0;
  assign {rec_eos, rec_offset, rec_match} = rec_valid ? mem[rd_ptr] : '0;
  always_comb begin
    pop = rec_valid & rec_ready;
    space = (cnt != FULL) | pop;
    take = match_valid & (sod | state == STREAM);
    hit = take & (|match);
    byte_off = sod ? '0 : off;
    mpush = hit & space;
    eos_push = (state == EOS) & ~sod & space;
    push = mpush | eos_push;
    wdata = eos_push ? {1'b1, off, {NUM_ENG{1'b0}}} : {1'b0, byte_off, match};
    state_n = (state == IDLE)   ? (sod ? STREAM : IDLE) :
              (state == STREAM) ? (eod ? EOS : STREAM) :
              (sod ? STREAM : (space ? IDLE : EOS));
    off_n = take ? byte_off + 1'b1 : byte_off;
    // sod in EOS abandons the pending eos record, which counts as a drop
    ovf_n = overflow | (hit & ~space) | ((state == EOS) & sod);
    wrap_n = (offset_wrap & ~sod) | (take & (&byte_off));
    cnt_n = cnt + (AW+1)'(push) - (AW+1)'(pop);
    hold_n = (FULL - cnt_n) <= MARGIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      off <= '0;
      hold <= 1'b0;
      overflow <= 1'b0;
      offset_wrap <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      off <= off_n;
      hold <= hold_n;
      overflow <= ovf_n;
      offset_wrap <= wrap_n;
    end
  end
  always_ff @(posedge clk)
    if (push & ~rst) mem[wr_ptr] <= wdata;
`ifdef MATCH_REPORT_COUNT_EN
  logic [OFFSET_W-1:0] mc_base;
  assign mc_base = sod ? '0 : match_count;
  always_ff @(posedge clk)
    match_count <= rst ? '0 : (hit & ~(&mc_base)) ? mc_base + 1'b1 : mc_base;
`endif
endmodule
